// File: rtl/pong_pkg.sv
// Shared definitions for the Pong game datapath.
// Direction encoding for the ball, serve directions after a point, and a
// saturating increment used by the score counters.
package pong_pkg;

    // One bit per axis: 0 moves towards higher column/row, 1 towards lower.
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    // After a point the ball is served towards the side that conceded it.
    localparam logic SERVE_PARA_CPU     = DIR_POS;
    localparam logic SERVE_PARA_JOGADOR = DIR_NEG;

    function automatic int incr_sat(input int valor, input int limite);
        return (valor >= limite) ? limite : valor + 1;
    endfunction

endpackage

// File: rtl/divisor_tick.sv
// Move-tick divider for the Pong datapath.
// Counts 0..DIV_TICK-1 while enabled and pulses tick during the last count.
// Ports:
//   clk    in   clock, rising edge
//   reset  in   synchronous active-high reset (count to 0)
//   clear  in   synchronous clear (count to 0)
//   enable in   count enable; when low the count is frozen
//   tick   out  high while enabled and the count is DIV_TICK-1
module divisor_tick #(
    parameter int unsigned DIV_TICK = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CW = (DIV_TICK > 2) ? $clog2(DIV_TICK) : 1;
    localparam logic [CW-1:0] Ultimo = CW'(DIV_TICK - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (enable) begin
            cnt_d = (cnt_q == Ultimo) ? '0 : cnt_q + CW'(1);
        end
    end

    // Gated by enable so a count frozen at the last value never emits a
    // duplicate tick while paused.
    assign tick = enable && (cnt_q == Ultimo);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fluxo_dados_jogo.sv
// Pong game datapath: ball motion, paddle motion, collisions and scoring on a
// discrete grid, advanced once per move tick.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   reseta_fd            holds the datapath in its initial state
//   pausa_fd             freezes all state including the tick divider
//   sobe, desce          player paddle up/down requests
//   bola_x, bola_y       ball position
//   raquete_j/_cpu       top row of player/CPU paddle
//   pontos_j/_cpu        scores
//   ganhou, perdeu       player / CPU reached the winning score
//   db_tick              one-cycle move-tick pulse
// Optional build macro PONG_CPU_LENTA_EN: the CPU paddle moves only on every
// second tick, starting with the second tick after clearing.
module fluxo_dados_jogo
    import pong_pkg::*;
#(
    parameter int unsigned LARGURA        = 16,
    parameter int unsigned ALTURA         = 12,
    parameter int unsigned TAM_RAQUETE    = 3,
    parameter int unsigned DIV_TICK       = 50000,
    parameter int unsigned PONTOS_VITORIA = 5,
    localparam int unsigned XW = $clog2(LARGURA),
    localparam int unsigned YW = $clog2(ALTURA),
    localparam int unsigned PW = $clog2(PONTOS_VITORIA + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          reseta_fd,
    input  logic          pausa_fd,
    input  logic          sobe,
    input  logic          desce,
    output logic [XW-1:0] bola_x,
    output logic [YW-1:0] bola_y,
    output logic [YW-1:0] raquete_j,
    output logic [YW-1:0] raquete_cpu,
    output logic [PW-1:0] pontos_j,
    output logic [PW-1:0] pontos_cpu,
    output logic          ganhou,
    output logic          perdeu,
    output logic          db_tick
);

    // Signed copies so intermediate positions may go negative.
    localparam int Larg   = int'(LARGURA);
    localparam int Alt    = int'(ALTURA);
    localparam int Tam    = int'(TAM_RAQUETE);
    localparam int Pv     = int'(PONTOS_VITORIA);
    localparam int TopMax = Alt - Tam;
    localparam int XMin   = 1;
    localparam int XMax   = Larg - 2;

    localparam logic [XW-1:0] XIni = XW'(LARGURA / 2);
    localparam logic [YW-1:0] YIni = YW'(ALTURA / 2);
    localparam logic [YW-1:0] RIni = YW'((ALTURA - TAM_RAQUETE) / 2);

    logic [XW-1:0] bola_x_q, bola_x_d;
    logic [YW-1:0] bola_y_q, bola_y_d;
    logic          dx_q, dx_d, dy_q, dy_d;
    logic [YW-1:0] raq_j_q, raq_j_d, raq_cpu_q, raq_cpu_d;
    logic [PW-1:0] pontos_j_q, pontos_j_d, pontos_cpu_q, pontos_cpu_d;
    logic          ganhou_q, ganhou_d, perdeu_q, perdeu_d;
    logic          tick, mover_cpu;

    divisor_tick #(
        .DIV_TICK(DIV_TICK)
    ) u_divisor (
        .clk   (clk),
        .reset (reset),
        .clear (reseta_fd),
        .enable(!reseta_fd && !pausa_fd),
        .tick  (tick)
    );

`ifdef PONG_CPU_LENTA_EN
    logic fase_q;

    always_ff @(posedge clk) begin
        if (reset || reseta_fd) begin
            fase_q <= 1'b0;
        end else if (tick && !ganhou_q && !perdeu_q) begin
            fase_q <= ~fase_q;
        end
    end

    assign mover_cpu = fase_q;
`else
    assign mover_cpu = 1'b1;
`endif

    always_comb begin
        int x, y, nx, ny, rj, rc, pj, pc;
        logic ndx, ndy;

        bola_x_d     = bola_x_q;
        bola_y_d     = bola_y_q;
        dx_d         = dx_q;
        dy_d         = dy_q;
        raq_j_d      = raq_j_q;
        raq_cpu_d    = raq_cpu_q;
        pontos_j_d   = pontos_j_q;
        pontos_cpu_d = pontos_cpu_q;
        ganhou_d     = ganhou_q;
        perdeu_d     = perdeu_q;

        x   = int'(bola_x_q);
        y   = int'(bola_y_q);
        rj  = int'(raq_j_q);
        rc  = int'(raq_cpu_q);
        pj  = int'(pontos_j_q);
        pc  = int'(pontos_cpu_q);
        ndx = dx_q;
        ndy = dy_q;

        // Vertical: reflect off the walls without dwelling on the edge row.
        ny = (dy_q == DIR_POS) ? y + 1 : y - 1;
        if (ny < 0 || ny > Alt - 1) begin
            ndy = ~dy_q;
            ny  = (dy_q == DIR_POS) ? y - 1 : y + 1;
        end

        // Horizontal: the paddle test uses the row the ball is moving into.
        if (x == XMin && dx_q == DIR_NEG) begin
            if (ny >= rj && ny <= rj + Tam - 1) begin
                ndx = DIR_POS;
                nx  = XMin + 1;
            end else begin
                pc  = incr_sat(pc, Pv);
                ndx = SERVE_PARA_JOGADOR;
                nx  = Larg / 2;
                ny  = Alt / 2;
            end
        end else if (x == XMax && dx_q == DIR_POS) begin
            if (ny >= rc && ny <= rc + Tam - 1) begin
                ndx = DIR_NEG;
                nx  = XMax - 1;
            end else begin
                pj  = incr_sat(pj, Pv);
                ndx = SERVE_PARA_CPU;
                nx  = Larg / 2;
                ny  = Alt / 2;
            end
        end else begin
            nx = (dx_q == DIR_POS) ? x + 1 : x - 1;
        end

        if (sobe && !desce && rj > 0) begin
            rj = rj - 1;
        end else if (desce && !sobe && rj < TopMax) begin
            rj = rj + 1;
        end

        // CPU tracks the current ball row.
        if (mover_cpu) begin
            if (y < rc && rc > 0) begin
                rc = rc - 1;
            end else if (y > rc + Tam - 1 && rc < TopMax) begin
                rc = rc + 1;
            end
        end

        if (tick && !ganhou_q && !perdeu_q) begin
            bola_x_d     = XW'(nx);
            bola_y_d     = YW'(ny);
            dx_d         = ndx;
            dy_d         = ndy;
            raq_j_d      = YW'(rj);
            raq_cpu_d    = YW'(rc);
            pontos_j_d   = PW'(pj);
            pontos_cpu_d = PW'(pc);
            ganhou_d     = (pj == Pv);
            perdeu_d     = (pc == Pv);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || reseta_fd) begin
            bola_x_q     <= XIni;
            bola_y_q     <= YIni;
            dx_q         <= DIR_POS;
            dy_q         <= DIR_POS;
            raq_j_q      <= RIni;
            raq_cpu_q    <= RIni;
            pontos_j_q   <= '0;
            pontos_cpu_q <= '0;
            ganhou_q     <= 1'b0;
            perdeu_q     <= 1'b0;
        end else begin
            bola_x_q     <= bola_x_d;
            bola_y_q     <= bola_y_d;
            dx_q         <= dx_d;
            dy_q         <= dy_d;
            raq_j_q      <= raq_j_d;
            raq_cpu_q    <= raq_cpu_d;
            pontos_j_q   <= pontos_j_d;
            pontos_cpu_q <= pontos_cpu_d;
            ganhou_q     <= ganhou_d;
            perdeu_q     <= perdeu_d;
        end
    end

    assign bola_x      = bola_x_q;
    assign bola_y      = bola_y_q;
    assign raquete_j   = raq_j_q;
    assign raquete_cpu = raq_cpu_q;
    assign pontos_j    = pontos_j_q;
    assign pontos_cpu  = pontos_cpu_q;
    assign ganhou      = ganhou_q;
    assign perdeu      = perdeu_q;
    assign db_tick     = tick;

endmodule

// File: tb/tb_fluxo_dados_jogo.sv
// Directed testbench for fluxo_dados_jogo on an 8x6 grid, 2-row paddles,
// tick every 4 cycles, match to 2 points.
module tb_fluxo_dados_jogo;

    logic       clk = 1'b0;
    logic       reset, reseta_fd, pausa_fd, sobe, desce;
    logic [2:0] bola_x, bola_y, raquete_j, raquete_cpu;
    logic [1:0] pontos_j, pontos_cpu;
    logic       ganhou, perdeu, db_tick;

    int n_tests = 0;
    int n_fail  = 0;

    fluxo_dados_jogo #(
        .LARGURA       (8),
        .ALTURA        (6),
        .TAM_RAQUETE   (2),
        .DIV_TICK      (4),
        .PONTOS_VITORIA(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .reseta_fd  (reseta_fd),
        .pausa_fd   (pausa_fd),
        .sobe       (sobe),
        .desce      (desce),
        .bola_x     (bola_x),
        .bola_y     (bola_y),
        .raquete_j  (raquete_j),
        .raquete_cpu(raquete_cpu),
        .pontos_j   (pontos_j),
        .pontos_cpu (pontos_cpu),
        .ganhou     (ganhou),
        .perdeu     (perdeu),
        .db_tick    (db_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance through the next move tick (bounded wait).
    task automatic next_tick();
        for (int i = 0; i < 16; i++) begin
            if (db_tick === 1'b1) begin
                step();
                return;
            end
            step();
        end
        n_tests++;
        n_fail++;
        $display("FAIL tick_timeout: got no db_tick in 16 cycles, expected one within 4");
    endtask

    task automatic test_reset();
        reset = 1'b1; reseta_fd = 1'b0; pausa_fd = 1'b0; sobe = 1'b0; desce = 1'b0;
        step();
        step();
        reset = 1'b0;
        n_tests++;
        if ({bola_x, bola_y} !== {3'd4, 3'd3}) begin
            n_fail++;
            $display("FAIL reset_bola: got (%0d,%0d) expected (4,3)", bola_x, bola_y);
        end
        n_tests++;
        if ({raquete_j, raquete_cpu} !== {3'd2, 3'd2}) begin
            n_fail++;
            $display("FAIL reset_raquetes: got j=%0d cpu=%0d expected 2,2", raquete_j, raquete_cpu);
        end
        n_tests++;
        if ({pontos_j, pontos_cpu, ganhou, perdeu, db_tick} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got pj=%0d pc=%0d g=%0b p=%0b t=%0b expected all 0",
                     pontos_j, pontos_cpu, ganhou, perdeu, db_tick);
        end
    endtask

    task automatic test_idle_motion();
        for (int c = 1; c <= 8; c++) begin
            n_tests++;
            if (db_tick !== ((c % 4) == 0)) begin
                n_fail++;
                $display("FAIL tick_cadencia c=%0d: got %0b expected %0b", c, db_tick,
                         (c % 4) == 0);
            end
            step();
            if (c == 4) begin
                n_tests++;
                if ({bola_x, bola_y} !== {3'd5, 3'd4}) begin
                    n_fail++;
                    $display("FAIL tick1_bola: got (%0d,%0d) expected (5,4)", bola_x, bola_y);
                end
            end
        end
        n_tests++;
        if ({bola_x, bola_y, raquete_cpu} !== {3'd6, 3'd5, 3'd3}) begin
            n_fail++;
            $display("FAIL tick2: got bola (%0d,%0d) cpu=%0d expected (6,5) cpu=3",
                     bola_x, bola_y, raquete_cpu);
        end
    endtask

    task automatic test_wall();
        // y=5 dy+ reflects to 4; x=6 also bounces off the CPU paddle (rows 3-4).
        next_tick();
        n_tests++;
        if ({bola_x, bola_y, raquete_cpu} !== {3'd5, 3'd4, 3'd4}) begin
            n_fail++;
            $display("FAIL parede: got bola (%0d,%0d) cpu=%0d expected (5,4) cpu=4",
                     bola_x, bola_y, raquete_cpu);
        end
        next_tick();
        n_tests++;
        if ({bola_x, bola_y} !== {3'd4, 3'd3}) begin
            n_fail++;
            $display("FAIL parede_dy: got (%0d,%0d) expected (4,3)", bola_x, bola_y);
        end
    endtask

    task automatic test_paddle_hit();
        sobe = 1'b1;
        next_tick();
        sobe = 1'b0;
        n_tests++;
        if ({bola_x, bola_y, raquete_j} !== {3'd3, 3'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL sobe: got bola (%0d,%0d) j=%0d expected (3,2) j=1",
                     bola_x, bola_y, raquete_j);
        end
        next_tick();
        next_tick();
        n_tests++;
        if ({bola_x, bola_y} !== {3'd1, 3'd0}) begin
            n_fail++;
            $display("FAIL chega_x1: got (%0d,%0d) expected (1,0)", bola_x, bola_y);
        end
        next_tick();
        n_tests++;
        if ({bola_x, bola_y, pontos_j, pontos_cpu, raquete_cpu} !==
            {3'd2, 3'd1, 2'd0, 2'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL rebate_j: got bola (%0d,%0d) pts %0d/%0d cpu=%0d expected (2,1) 0/0 cpu=0",
                     bola_x, bola_y, pontos_j, pontos_cpu, raquete_cpu);
        end
        sobe = 1'b1; desce = 1'b1;
        next_tick();
        sobe = 1'b0; desce = 1'b0;
        n_tests++;
        if ({bola_x, bola_y, raquete_j} !== {3'd3, 3'd2, 3'd1}) begin
            n_fail++;
            $display("FAIL ambos_botoes: got bola (%0d,%0d) j=%0d expected (3,2) j=1",
                     bola_x, bola_y, raquete_j);
        end
    endtask

    task automatic test_reseta_fd();
        reseta_fd = 1'b1;
        step();
        reseta_fd = 1'b0;
        n_tests++;
        if ({bola_x, bola_y, raquete_j, raquete_cpu, pontos_j, pontos_cpu, ganhou, perdeu} !==
            {3'd4, 3'd3, 3'd2, 3'd2, 2'd0, 2'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reseta_fd: got bola (%0d,%0d) j=%0d cpu=%0d pts %0d/%0d g=%0b p=%0b",
                     bola_x, bola_y, raquete_j, raquete_cpu, pontos_j, pontos_cpu, ganhou, perdeu);
        end
    endtask

    task automatic test_miss();
        desce = 1'b1;
        for (int t = 1; t <= 3; t++) next_tick();
        n_tests++;
        if (raquete_j !== 3'd4) begin
            n_fail++;
            $display("FAIL desce_limite: got j=%0d expected 4", raquete_j);
        end
        for (int t = 4; t <= 8; t++) next_tick();
        n_tests++;
        if ({bola_x, bola_y, pontos_j, pontos_cpu, perdeu} !== {3'd4, 3'd3, 2'd0, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL ponto_cpu1: got bola (%0d,%0d) pts %0d/%0d p=%0b expected (4,3) 0/1 p=0",
                     bola_x, bola_y, pontos_j, pontos_cpu, perdeu);
        end
        next_tick();
        n_tests++;
        if ({bola_x, bola_y} !== {3'd3, 3'd4}) begin
            n_fail++;
            $display("FAIL saque_jogador: got (%0d,%0d) expected (3,4)", bola_x, bola_y);
        end
    endtask

    task automatic test_second_point();
        for (int t = 10; t <= 12; t++) next_tick();
        n_tests++;
        if ({bola_x, bola_y, pontos_j, pontos_cpu, ganhou, perdeu, raquete_cpu} !==
            {3'd4, 3'd3, 2'd0, 2'd2, 1'b0, 1'b1, 3'd3}) begin
            n_fail++;
            $display("FAIL ponto_cpu2: got bola (%0d,%0d) pts %0d/%0d g=%0b p=%0b cpu=%0d",
                     bola_x, bola_y, pontos_j, pontos_cpu, ganhou, perdeu, raquete_cpu);
        end
        desce = 1'b0; sobe = 1'b1;
        for (int c = 0; c < 12; c++) step();
        sobe = 1'b0;
        n_tests++;
        if ({bola_x, bola_y, raquete_j, raquete_cpu, pontos_j, pontos_cpu, perdeu} !==
            {3'd4, 3'd3, 3'd4, 3'd3, 2'd0, 2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL congelado: got bola (%0d,%0d) j=%0d cpu=%0d pts %0d/%0d p=%0b",
                     bola_x, bola_y, raquete_j, raquete_cpu, pontos_j, pontos_cpu, perdeu);
        end
        test_reseta_fd();
    endtask

    task automatic test_pause();
        step();
        step();
        pausa_fd = 1'b1;
        for (int c = 0; c < 10; c++) begin
            n_tests++;
            if (db_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL pausa_tick c=%0d: got %0b expected 0", c, db_tick);
            end
            step();
        end
        pausa_fd = 1'b0;
        n_tests++;
        if ({bola_x, bola_y, db_tick} !== {3'd4, 3'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL pausa_estado: got bola (%0d,%0d) tick=%0b expected (4,3) 0",
                     bola_x, bola_y, db_tick);
        end
        step();
        n_tests++;
        if (db_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL retoma_tick: got %0b expected 1", db_tick);
        end
        step();
        n_tests++;
        if ({bola_x, bola_y} !== {3'd5, 3'd4}) begin
            n_fail++;
            $display("FAIL retoma_bola: got (%0d,%0d) expected (5,4)", bola_x, bola_y);
        end
    endtask

    initial begin
        test_reset();
        test_idle_motion();
        test_wall();
        test_paddle_hit();
        test_reseta_fd();
        test_miss();
        test_second_point();
        test_pause();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000 time units, expected finish");
        $fatal(1);
    end

endmodule
